// File: rtl/sar_pkg.sv
// Shared state encoding, averaging constants and width helper for the SAR ADC controller.
package sar_pkg;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SAMPLE  = 2'd1;
   localparam logic [1:0] CONVERT = 2'd2;
   localparam logic [1:0] HOLD    = 2'd3;

   localparam int unsigned AVG_CNT   = 4;
   localparam int unsigned AVG_SHIFT = 2;

   // Counter/select width that never collapses to zero bits.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sar_bit_engine.sv
// Successive-approximation register: one binary-search conversion per go pulse,
// SETTLE_CYC cycles per bit trial, comparator captured on the last settle cycle.
module sar_bit_engine
   import sar_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned SETTLE_CYC = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic             clr,
   input  logic             cmp,
   output logic [WIDTH-1:0] dac_code,
   output logic [WIDTH-1:0] code_out,
   output logic             done
);

   localparam int unsigned SET_W = clog2_min1(SETTLE_CYC);
   localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

   logic [WIDTH-1:0] mask_q;
   logic [SET_W-1:0] settle_q;
   logic             active_q;
   logic             capture;

   // code_out/done are combinational so the owner can load the final code on the
   // same edge the last bit is resolved.
   always_comb begin
      capture  = active_q && (settle_q == SET_W'(SETTLE_CYC - 1));
      code_out = cmp ? dac_code : (dac_code & ~mask_q);
      code_out = code_out | (mask_q >> 1);
      done     = capture && mask_q[0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dac_code <= '0;
         mask_q   <= '0;
         settle_q <= '0;
         active_q <= 1'b0;
      end else if (clr) begin
         dac_code <= '0;
         mask_q   <= '0;
         settle_q <= '0;
         active_q <= 1'b0;
      end else if (go) begin
         dac_code <= MSB_MASK;
         mask_q   <= MSB_MASK;
         settle_q <= '0;
         active_q <= 1'b1;
      end else if (active_q) begin
         if (capture) begin
            dac_code <= code_out;
            mask_q   <= mask_q >> 1;
            settle_q <= '0;
            if (mask_q[0]) active_q <= 1'b0;
         end else begin
            settle_q <= settle_q + SET_W'(1);
         end
      end
   end

endmodule

// File: rtl/sar_ctrl_multi.sv
// Multi-channel SAR ADC controller: start/busy, single or scan mode, valid/ready result.
// Optional SAR_AVG_EN: four conversions per channel averaged before the result is offered.
module sar_ctrl_multi
   import sar_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned SAMPLE_CYC = 2,
   parameter int unsigned SETTLE_CYC = 1,
   localparam int unsigned CH_W      = clog2_min1(NUM_CH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             scan_en,
   input  logic [CH_W-1:0]  ch_sel,
   input  logic             cmp,
   output logic             sample,
   output logic [WIDTH-1:0] dac_code,
   output logic [CH_W-1:0]  ch_mux,
   output logic [WIDTH-1:0] result,
   output logic [CH_W-1:0]  result_ch,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             busy,
   output logic             conv_done
);

   localparam int unsigned SMP_W = clog2_min1(SAMPLE_CYC);
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   logic [1:0]       state_q, state_d;
   logic [SMP_W-1:0] samp_cnt_q, samp_cnt_d;
   logic             scan_q, scan_d;
   logic [CH_W-1:0]  ch_mux_d, result_ch_d;
   logic [WIDTH-1:0] result_d;
   logic             valid_d, sample_d, busy_d, conv_done_d;
   logic             eng_go, eng_clr, eng_done;
   logic [WIDTH-1:0] eng_code;

`ifdef SAR_AVG_EN
   localparam int unsigned ACC_W = WIDTH + 2;
   logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
   logic [1:0]       avg_cnt_q, avg_cnt_d;
`endif

   sar_bit_engine #(
      .WIDTH      (WIDTH),
      .SETTLE_CYC (SETTLE_CYC)
   ) u_engine (
      .clk      (clk),
      .reset    (reset),
      .go       (eng_go),
      .clr      (eng_clr),
      .cmp      (cmp),
      .dac_code (dac_code),
      .code_out (eng_code),
      .done     (eng_done)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      samp_cnt_d  = samp_cnt_q;
      scan_d      = scan_q;
      ch_mux_d    = ch_mux;
      result_d    = result;
      result_ch_d = result_ch;
      valid_d     = result_valid;
      conv_done_d = 1'b0;
      eng_go      = 1'b0;
      eng_clr     = 1'b0;
`ifdef SAR_AVG_EN
      acc_d       = acc_q;
      avg_cnt_d   = avg_cnt_q;
      acc_sum     = acc_q + ACC_W'(eng_code);
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               scan_d     = scan_en;
               ch_mux_d   = scan_en ? '0 : ch_sel;
               samp_cnt_d = '0;
               state_d    = SAMPLE;
`ifdef SAR_AVG_EN
               acc_d      = '0;
               avg_cnt_d  = '0;
`endif
            end
         end
         SAMPLE: begin
            if (samp_cnt_q == SMP_W'(SAMPLE_CYC - 1)) begin
               eng_go  = 1'b1;
               state_d = CONVERT;
            end else begin
               samp_cnt_d = samp_cnt_q + SMP_W'(1);
            end
         end
         CONVERT: begin
            if (eng_done) begin
`ifdef SAR_AVG_EN
               if (avg_cnt_q == 2'(AVG_CNT - 1)) begin
                  result_d    = WIDTH'(acc_sum >> AVG_SHIFT);
                  result_ch_d = ch_mux;
                  valid_d     = 1'b1;
                  state_d     = HOLD;
               end else begin
                  // Next back-to-back conversion of the same channel needs a fresh sample.
                  acc_d      = acc_sum;
                  avg_cnt_d  = avg_cnt_q + 2'd1;
                  eng_clr    = 1'b1;
                  samp_cnt_d = '0;
                  state_d    = SAMPLE;
               end
`else
               result_d    = eng_code;
               result_ch_d = ch_mux;
               valid_d     = 1'b1;
               state_d     = HOLD;
`endif
            end
         end
         HOLD: begin
            if (result_ready) begin
               valid_d = 1'b0;
               eng_clr = 1'b1;
               if (scan_q && (ch_mux != LAST_CH)) begin
                  ch_mux_d   = ch_mux + CH_W'(1);
                  samp_cnt_d = '0;
                  state_d    = SAMPLE;
`ifdef SAR_AVG_EN
                  acc_d      = '0;
                  avg_cnt_d  = '0;
`endif
               end else begin
                  conv_done_d = 1'b1;
                  state_d     = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      sample_d = (state_d == SAMPLE);
      busy_d   = (state_d != IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         samp_cnt_q   <= '0;
         scan_q       <= 1'b0;
         ch_mux       <= '0;
         result       <= '0;
         result_ch    <= '0;
         result_valid <= 1'b0;
         sample       <= 1'b0;
         busy         <= 1'b0;
         conv_done    <= 1'b0;
      end else begin
         state_q      <= state_d;
         samp_cnt_q   <= samp_cnt_d;
         scan_q       <= scan_d;
         ch_mux       <= ch_mux_d;
         result       <= result_d;
         result_ch    <= result_ch_d;
         result_valid <= valid_d;
         sample       <= sample_d;
         busy         <= busy_d;
         conv_done    <= conv_done_d;
      end
   end

`ifdef SAR_AVG_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q     <= '0;
         avg_cnt_q <= '0;
      end else begin
         acc_q     <= acc_d;
         avg_cnt_q <= avg_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_sar_ctrl_multi.sv
// Self-checking bench for sar_ctrl_multi (WIDTH=8, NUM_CH=4, SAMPLE_CYC=2, SETTLE_CYC=1)
// with an ideal behavioural comparator and a result scoreboard.
module tb_sar_ctrl_multi;

`ifdef SAR_AVG_EN
   localparam int AVG_MUL = 4;
`else
   localparam int AVG_MUL = 1;
`endif
   localparam int LAT = AVG_MUL * (2 + 8 * 1);

   typedef struct {
      logic            scan;
      logic [1:0]      ch;
      logic [3:0][7:0] vin;
      int              n_res;
      logic [3:0][7:0] exp_code;
   } vec_t;

   typedef struct {
      logic [7:0] code;
      logic [1:0] ch;
   } sb_t;

   logic       clk = 1'b0;
   logic       reset, start, scan_en, cmp, result_ready;
   logic [1:0] ch_sel, ch_mux, result_ch;
   logic [7:0] dac_code, result;
   logic       sample, result_valid, busy, conv_done;

   logic [3:0][7:0] vin_tab;
   logic [7:0]      cur_vin;
   logic            alt;
   int              conv_idx;
   int              n_cmp = 0;
   int              n_bad = 0;
   int              done_cnt = 0;
   sb_t             sb[$];
   sb_t             mon_e;
   vec_t            vecs[6];
   logic [7:0]      trial_seq[8];

   sar_ctrl_multi #(
      .WIDTH      (8),
      .NUM_CH     (4),
      .SAMPLE_CYC (2),
      .SETTLE_CYC (1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .scan_en      (scan_en),
      .ch_sel       (ch_sel),
      .cmp          (cmp),
      .sample       (sample),
      .dac_code     (dac_code),
      .ch_mux       (ch_mux),
      .result       (result),
      .result_ch    (result_ch),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .busy         (busy),
      .conv_done    (conv_done)
   );

   always #5 clk = ~clk;

   assign cur_vin = alt ? (conv_idx[0] ? 8'h43 : 8'h40) : vin_tab[ch_mux];
   assign cmp     = (cur_vin >= dac_code);

   always @(negedge sample) conv_idx++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: pop on every accepted result; conv_done must follow the last one.
   always @(negedge clk) begin
      if (!reset) begin
         if (result_valid && result_ready) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 32'd1, 32'd0);
            end else begin
               mon_e = sb.pop_front();
               check("result", 32'(result), 32'(mon_e.code));
               check("result_ch", 32'(result_ch), 32'(mon_e.ch));
            end
         end
         if (conv_done) begin
            done_cnt++;
            check("done_after_last", 32'(sb.size()), 32'd0);
         end
      end
   end

   function automatic vec_t mk(input logic scan, input logic [1:0] ch,
                               input logic [7:0] v0, v1, v2, v3,
                               input logic [7:0] e0, e1, e2, e3);
      vec_t v;
      v.scan  = scan;
      v.ch    = ch;
      v.vin   = {v3, v2, v1, v0};
      v.n_res = scan ? 4 : 1;
      v.exp_code = {e3, e2, e1, e0};
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [7:0] code, input logic [1:0] ch);
      sb_t e;
      e.code = code;
      e.ch   = ch;
      sb.push_back(e);
   endtask

   task automatic start_seq(input logic scan, input logic [1:0] ch);
      tick();
      scan_en = scan;
      ch_sel  = ch;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   task automatic wait_valid(input string name, input int exp_lat);
      int cyc = 0;
      while (!result_valid && cyc < 400) begin
         tick();
         cyc++;
      end
      check(name, 32'(cyc), 32'(exp_lat));
   endtask

   task automatic wait_done(input int d0);
      int cyc = 0;
      while (done_cnt == d0 && cyc < 2000) begin
         tick();
         cyc++;
      end
      check("conv_done_seen", 32'(done_cnt != d0), 32'd1);
      repeat (3) tick();
      check("conv_done_once", 32'(done_cnt - d0), 32'd1);
      check("busy_idle", 32'(busy), 32'd0);
      check("sb_drained", 32'(sb.size()), 32'd0);
   endtask

   task automatic run_vec(input vec_t v);
      int d0 = done_cnt;
      alt     = 1'b0;
      vin_tab = v.vin;
      for (int i = 0; i < v.n_res; i++)
         push_exp(v.exp_code[i], v.scan ? 2'(i) : v.ch);
      start_seq(v.scan, v.ch);
      check("busy_after_start", 32'(busy), 32'd1);
      wait_valid("latency", LAT);
      wait_done(d0);
   endtask

   initial begin
      int bad;
      int d0;
      logic [7:0] r;
      logic [1:0] c, m;

      vecs[0] = mk(1'b0, 2'd2, 8'h5A, 8'h5A, 8'hA5, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00);
      vecs[1] = mk(1'b0, 2'd0, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
      vecs[2] = mk(1'b0, 2'd1, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00);
      vecs[3] = mk(1'b0, 2'd3, 8'h7F, 8'h7F, 8'h7F, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00);
      vecs[4] = mk(1'b0, 2'd1, 8'hFF, 8'h01, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00);
      vecs[5] = mk(1'b1, 2'd2, 8'h10, 8'h80, 8'hFF, 8'h3C, 8'h10, 8'h80, 8'hFF, 8'h3C);
      trial_seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

      reset = 1'b1; start = 1'b0; scan_en = 1'b0; ch_sel = 2'd0;
      result_ready = 1'b1; alt = 1'b0; conv_idx = 0; vin_tab = '0;
      #1;
      check("rst_sample", 32'(sample), 32'd0);
      check("rst_dac", 32'(dac_code), 32'd0);
      check("rst_valid", 32'(result_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_ch_mux", 32'(ch_mux), 32'd0);
      repeat (3) tick();
      reset = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // DAC trial sequence for vin=0xA5 on channel 2.
      d0 = done_cnt;
      vin_tab = {8'h00, 8'hA5, 8'h00, 8'h00};
      push_exp(8'hA5, 2'd2);
      start_seq(1'b0, 2'd2);
      check("sample_high", 32'(sample), 32'd1);
      check("ch_mux_single", 32'(ch_mux), 32'd2);
      tick();
      tick();
      check("sample_low", 32'(sample), 32'd0);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("trial_%0d", i), 32'(dac_code), 32'(trial_seq[i]));
         tick();
      end
`ifndef SAR_AVG_EN
      check("dac_hold_final", 32'(dac_code), 32'hA5);
`endif
      wait_done(d0);
      check("dac_idle_zero", 32'(dac_code), 32'd0);

      // Backpressure in scan mode: 20 stalled cycles on channel 0.
      d0 = done_cnt;
      result_ready = 1'b0;
      vin_tab = {8'h3C, 8'hFF, 8'h80, 8'h10};
      for (int i = 0; i < 4; i++) push_exp(vin_tab[i], 2'(i));
      start_seq(1'b1, 2'd3);
      wait_valid("bp_latency", LAT);
      r = result; c = result_ch; m = ch_mux;
      bad = 0;
      repeat (20) begin
         tick();
         if (result !== r || result_ch !== c || result_valid !== 1'b1 || sample !== 1'b0 ||
             ch_mux !== m || dac_code !== r || conv_done !== 1'b0)
            bad++;
      end
      check("bp_stable", 32'(bad), 32'd0);
      check("bp_code", 32'(r), 32'h10);
      check("bp_ch", 32'(c), 32'd0);
      check("bp_pending", 32'(sb.size()), 32'd4);
      result_ready = 1'b1;
      wait_done(d0);

      // Ignored start while busy, then reset during the bit-4 trial.
      vin_tab = {8'h00, 8'hA5, 8'h00, 8'h00};
      push_exp(8'hA5, 2'd2);
      start_seq(1'b0, 2'd2);
      tick();
      tick();
      start = 1'b1;
      ch_sel = 2'd1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("no_restart_dac", 32'(dac_code), 32'hB0);
      check("no_restart_sample", 32'(sample), 32'd0);
      check("no_restart_ch", 32'(ch_mux), 32'd2);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_dac", 32'(dac_code), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ch_mux", 32'(ch_mux), 32'd0);
      check("mid_rst_valid", 32'(result_valid), 32'd0);
      check("mid_rst_conv_done", 32'(conv_done), 32'd0);
      check("mid_rst_result_ch", 32'(result_ch), 32'd0);
      sb.delete();
      tick();
      reset = 1'b0;
      tick();
      check("post_rst_idle", 32'(busy), 32'd0);
      run_vec(vecs[0]);

`ifdef SAR_AVG_EN
      // Input alternating 0x40/0x43 across the four conversions averages to 0x41.
      d0 = done_cnt;
      push_exp(8'h41, 2'd1);
      start_seq(1'b0, 2'd1);
      alt = 1'b1;
      conv_idx = 0;
      wait_valid("avg_latency", 40);
      wait_done(d0);
      alt = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sar_ctrl_multi.md
Name: sar_ctrl_multi

Overview:
Parametrised successive-approximation ADC controller; next generation of the 4-bit SAR logic used in the tt_um top.
- Drives an external binary-weighted DAC and reads one comparator bit.
- Generalised to WIDTH bits and NUM_CH analog mux channels, with a configurable comparator settle time.
- Adds a start/busy interface, single-channel or round-robin scan mode, and a valid/ready result handshake with backpressure.

Parameters:
WIDTH, 8, conversion resolution in bits (2..16)
NUM_CH, 4, analog mux channels (1..16); CH_W = max(1, $clog2(NUM_CH)) is a localparam
SAMPLE_CYC, 2, cycles sample is held high before bit trials (>=1)
SETTLE_CYC, 1, cycles per bit trial before cmp is captured (>=1)

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-high reset
start  in  1  request a sequence; accepted only in IDLE
scan_en  in  1  sampled at start: 0 = convert ch_sel once, 1 = convert channels 0..NUM_CH-1 in order
ch_sel  in  CH_W  channel for single mode, sampled at start
cmp  in  1  comparator: 1 = Vin >= Vdac(dac_code)
sample  out  1  sample/hold control, high during SAMPLE
dac_code  out  WIDTH  trial code to DAC
ch_mux  out  CH_W  analog mux select, stable from SAMPLE through end of CONVERT
result  out  WIDTH  converted code
result_ch  out  CH_W  channel of result
result_valid  out  1  result available
result_ready  in  1  consumer accepts result when high with result_valid
busy  out  1  high in any state except IDLE
conv_done  out  1  one-cycle pulse after last result of a sequence is accepted

Behaviour:
- Reset (async, immediate): state = IDLE; sample, result_valid, busy and conv_done = 0; dac_code, result, result_ch and ch_mux = 0.
- A reset mid-conversion aborts the sequence and discards partial data.
- States: IDLE, SAMPLE, CONVERT, HOLD.
- IDLE: on start=1, latch scan_en and ch_sel. ch_mux <= scan_en ? 0 : ch_sel. Go to SAMPLE. A start outside IDLE is ignored.
- SAMPLE: sample=1 and dac_code=0 for SAMPLE_CYC cycles. Then enter CONVERT with bit index = WIDTH-1 and dac_code = 1<<(WIDTH-1).
- CONVERT, bit trial k:
  - Hold the trial code for SETTLE_CYC cycles.
  - On the last cycle, capture cmp: cmp=1 keeps bit k, cmp=0 clears it.
  - If k>0, set bit k-1 in the same edge.
  - After k=0, load result and result_ch, assert result_valid, go to HOLD.
- Latency: start accepted (edge N) -> result_valid high at edge N + SAMPLE_CYC + WIDTH*SETTLE_CYC.
- HOLD: result, result_ch and result_valid are stable until result_valid && result_ready.
- On that handshake, result_valid drops next cycle, then:
  - scan mode with more channels: ch_mux++ and go to SAMPLE.
  - otherwise: pulse conv_done and go to IDLE.
- Backpressure stalls the sequence; no result is ever dropped.
- result_ready high in the cycle valid rises completes the handshake in that cycle; zero HOLD wait.
- dac_code holds the final code during HOLD and returns to 0 in IDLE.
- cmp is don't-care outside the capture cycles.
- No arithmetic beyond bit set/clear.
- A channel counter at NUM_CH-1 terminates the scan; it never wraps. For NUM_CH=1, scan mode equals single mode.

Optional Feature:
SAR_AVG_EN
- Defined:
  - Each channel is converted 4 times back to back, each conversion with its own SAMPLE.
  - Codes are summed in a (WIDTH+2)-bit accumulator; result = sum >> 2 (truncation).
  - result_valid is raised only after the 4th conversion.
  - Latency is 4x the base latency per channel.
  - The accumulator clears on reset and at each channel start.
- Undefined: single conversion per channel; no accumulator logic present.

Decomposition:
- Package sar_pkg: state enum (IDLE, SAMPLE, CONVERT, HOLD), AVG_CNT = 4 and AVG_SHIFT = 2 constants, and a clog2-min-1 helper function.
- Sub-module sar_bit_engine: per-conversion successive-approximation register with bit index, settle counter and trial/keep logic.
  - Engine ports: go, cmp, dac_code, code_out, done.
- The top FSM owns channel sequencing, the handshake and averaging.

Test Plan:
All scenarios use WIDTH=8, SETTLE_CYC=1, SAMPLE_CYC=2 and a behavioural comparator cmp = (vin >= dac_code).
- Single mode, ch_sel=2, vin=0xA5, result_ready=1: result_valid rises exactly 10 cycles after start; result=0xA5, result_ch=2; conv_done pulses once; busy returns to 0.
- Extremes: vin=0x00 gives 0x00; vin=0xFF gives 0xFF; vin=0x80 gives 0x80. Check the dac_code trial sequence 0x80, 0xC0, ... per cycle for vin=0xA5.
- Scan mode, NUM_CH=4, vin per channel {0x10, 0x80, 0xFF, 0x3C}: four results in channel order 0..3 with matching codes; conv_done only after the 4th handshake.
- Backpressure: result_ready low for 20 cycles in scan mode. result and result_ch stay stable, no SAMPLE of the next channel begins, and no result is lost after ready rises.
- Reset asserted mid-CONVERT (bit 4), and start pulsed while busy:
  - All outputs go to their reset values at once.
  - The ignored start causes no restart.
  - A fresh start after reset converts correctly.
- With SAR_AVG_EN, vin toggling 0x40/0x43 across the four conversions: result = (0x40+0x43+0x40+0x43) >> 2 = 0x41; result_valid at 40 cycles.
